// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enigma_pkg
//  Description : Shared constants and the TX state encoding used by the
//                Enigma output-side UART transmitter.
//                - ASCII_CR / ASCII_LF      : line-ending bytes
//                - DEFAULT_CLKS_PER_BIT     : 12 MHz / 115200 baud
//                - tx_state_t               : 2-bit TX FSM encoding
//  Revision    : 1.0  initial release
// ============================================================================
package enigma_pkg;

    localparam logic [7:0] ASCII_CR             = 8'h0D;
    localparam logic [7:0] ASCII_LF             = 8'h0A;
    localparam int         DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage : enigma_pkg
`default_nettype wire

// File: rtl/enigma_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : enigma_sync_fifo
//  Description : Single-clock byte FIFO, depth 2**AW, registered occupancy.
//                No fall-through: a byte written at edge N is visible on
//                dout (and empty deasserts) only after that edge.
//  Ports       : i_clock  - clock, all logic on posedge
//                i_reset  - synchronous active-high reset (flushes FIFO)
//                push/din - write strobe and data (ignored while full)
//                pop      - read strobe (ignored while empty)
//                dout     - head-of-queue byte
//                full     - occupancy == 2**AW
//                empty    - occupancy == 0
//                count    - current occupancy (AW+1 bits)
//  Revision    : 1.0  initial release
// ============================================================================
module enigma_sync_fifo #(
    parameter int AW = 4
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int          c_DEPTH     = 2 ** AW;
    localparam logic [AW:0] c_DEPTH_CNT = (AW + 1)'(c_DEPTH);

    logic [7:0]    r_mem [c_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    // Full/empty come from the registered count, so a pop on the same edge
    // never makes room for a push into a full FIFO.
    assign full      = (r_count == c_DEPTH_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through the pointers.
    always_ff @(posedge i_clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule : enigma_sync_fifo
`default_nettype wire

// File: rtl/enigma_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : enigma_uart_tx
//  Description : Output-side transmitter of the Enigma cipher core. Bytes
//                strobed in (no backpressure) are queued in a FIFO and sent
//                as 8N1 UART frames, LSB first.
//  Ports       : i_clock    - clock, all logic on posedge
//                i_reset    - synchronous active-high reset
//                i_ready    - byte strobe, one byte per high cycle
//                i_data     - byte sampled while i_ready=1
//                o_tx       - serial line, idles high
//                o_busy     - FIFO non-empty or frame in flight
//                o_full     - FIFO holds 2**FIFO_AW bytes
//                o_overflow - sticky, strobe seen while full
//  Config      : `ENIGMA_TX_CRLF_EN - when defined, every transmitted 0x0D
//                is followed by an automatically generated 0x0A frame.
//  Revision    : 1.0  initial release
// ============================================================================
module enigma_uart_tx
    import enigma_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_ready,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int                 c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   c_ONE      = (FIFO_AW + 1)'(1);

    // Registered state
    tx_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_busy;
    logic               r_overflow;

    // Next-state values
    tx_state_t          w_state_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [2:0]         w_idx_next;
    logic [7:0]         w_shift_next;
    logic               w_tx_next;
    logic               w_pop;

    // FIFO interface
    logic               w_push_ok;
    logic [7:0]         w_fifo_dout;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [FIFO_AW:0]   w_fifo_count;
    logic               w_fifo_nonempty_next;

    // Line-feed insertion hooks (tied off when the feature is not built)
    logic               w_lf_pending;
    logic               w_lf_pending_next;

    logic               w_cnt_last;
    logic               w_busy_next;

    assign w_push_ok  = i_ready & ~w_fifo_full;
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    enigma_sync_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .push    (i_ready),
        .pop     (w_pop),
        .din     (i_data),
        .dout    (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // TX FSM: next-state / datapath
    // o_tx is registered, so each transition also computes the line level
    // for the cycle that follows it.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (w_lf_pending) begin
                    // Generated LF takes priority and leaves the FIFO alone.
                    w_shift_next = ASCII_LF;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = START;
                    w_tx_next    = 1'b0;
                end else if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = START;
                    w_tx_next    = 1'b0;
                end
            end

            START: begin
                w_tx_next = 1'b0;
                if (w_cnt_last) begin
                    w_cnt_next   = '0;
                    w_state_next = DATA;
                    w_tx_next    = r_shift[0];
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            DATA: begin
                if (w_cnt_last) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_idx_next   = r_bit_idx + 1'b1;
                        w_tx_next    = r_shift[1];
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            STOP: begin
                w_tx_next = 1'b1;
                if (w_cnt_last) begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // Busy is registered from next-state values so it rises with the
    // accepting edge and falls on the edge that returns to an empty IDLE.
    assign w_fifo_nonempty_next = w_push_ok
                                | (w_fifo_count > c_ONE)
                                | ((w_fifo_count == c_ONE) & ~w_pop);
    assign w_busy_next = (w_state_next != IDLE) | w_fifo_nonempty_next | w_lf_pending_next;

    // ------------------------------------------------------------------
    // TX FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            if (i_ready & w_fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef ENIGMA_TX_CRLF_EN
    // r_frame_cr marks a frame whose byte came from the FIFO as 0x0D; the
    // generated LF frame clears it so insertion never chains.
    logic r_frame_cr;
    logic r_lf_pending;
    logic w_stop_done;
    logic w_load_lf;

    assign w_stop_done       = (r_state == STOP) & w_cnt_last;
    assign w_load_lf         = (r_state == IDLE) & r_lf_pending;
    assign w_lf_pending      = r_lf_pending;
    assign w_lf_pending_next = (w_stop_done & r_frame_cr) | (r_lf_pending & ~w_load_lf);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_frame_cr   <= 1'b0;
            r_lf_pending <= 1'b0;
        end else begin
            if (w_pop) begin
                r_frame_cr <= (w_fifo_dout == ASCII_CR);
            end else if (w_load_lf) begin
                r_frame_cr <= 1'b0;
            end
            r_lf_pending <= w_lf_pending_next;
        end
    end
`else
    assign w_lf_pending      = 1'b0;
    assign w_lf_pending_next = 1'b0;
`endif

    assign o_tx       = r_tx;
    assign o_busy     = r_busy;
    assign o_full     = w_fifo_full;
    assign o_overflow = r_overflow;

endmodule : enigma_uart_tx
`default_nettype wire

// File: tb/tb_enigma_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enigma_uart_tx
//  Description : Self-checking bench for enigma_uart_tx. A line monitor
//                decodes frames from o_tx into a queue; each test pushes the
//                bytes it expects on the line and compares in order.
//                A second instance with CLKS_PER_BIT=100 exercises the full
//                and overflow behaviour while a frame is stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_enigma_uart_tx;

    localparam int CPB      = 4;
    localparam int CPB_SLOW = 100;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Fast instance
    logic       rst = 1'b1;
    logic       rdy = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx, busy, full, ovf;

    // Slow instance
    logic       s_rst = 1'b1;
    logic       s_rdy = 1'b0;
    logic [7:0] s_din = 8'h00;
    logic       s_tx, s_busy, s_full, s_ovf;

    enigma_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) u_dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_ready    (rdy),
        .i_data     (din),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_full     (full),
        .o_overflow (ovf)
    );

    enigma_uart_tx #(.CLKS_PER_BIT(CPB_SLOW), .FIFO_AW(4)) u_dut_slow (
        .i_clock    (clk),
        .i_reset    (s_rst),
        .i_ready    (s_rdy),
        .i_data     (s_din),
        .o_tx       (s_tx),
        .o_busy     (s_busy),
        .o_full     (s_full),
        .o_overflow (s_ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_start_q[$];

    // ------------------------------------------------------------------
    // Line monitor: samples at negedge, mid-bit, fast instance only.
    // ------------------------------------------------------------------
    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    int         mon_err    = 0;
    bit         mon_active = 1'b0;
    int         mon_k      = 0;
    int         mon_start  = 0;
    logic [7:0] mon_byte   = 8'h00;

    always @(negedge clk) begin
        if (rst_seen) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_k      = 0;
                mon_start  = cyc;
            end
        end else begin
            mon_k = mon_k + 1;
            if ((mon_k % CPB) == CPB / 2) begin
                if (mon_k / CPB == 0) begin
                    if (tx !== 1'b0) mon_err = mon_err + 1;
                end else if (mon_k / CPB <= 8) begin
                    mon_byte[mon_k / CPB - 1] = tx;
                end else begin
                    if (tx !== 1'b1) mon_err = mon_err + 1;
                end
            end
            if (mon_k == 10 * CPB - 1) begin
                rx_q.push_back(mon_byte);
                rx_start_q.push_back(mon_start);
                mon_active = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        rdy = 1'b1;
        din = b;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
        rx_q.delete();
        rx_start_q.delete();
    endtask

    task automatic settle_idle(input int max_cycles, output bit timed_out);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        timed_out = (busy !== 1'b0);
        repeat (3) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        s_rst = 1'b0;
        @(negedge clk);
        n_checks++; if (tx !== 1'b1)    $display("FAIL reset_tx: got %b want 1", tx);    else n_pass++;
        n_checks++; if (busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (full !== 1'b0)  $display("FAIL reset_full: got %b want 0", full); else n_pass++;
        n_checks++; if (ovf !== 1'b0)   $display("FAIL reset_ovf: got %b want 0", ovf);   else n_pass++;
        n_checks++; if (s_tx !== 1'b1)  $display("FAIL reset_s_tx: got %b want 1", s_tx); else n_pass++;
        n_checks++; if (s_busy !== 1'b0) $display("FAIL reset_s_busy: got %b want 0", s_busy); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       e;
        int         k;
        bit         to;
        b = 8'h41;
        exp_q.push_back(b);
        strobe(b);
        // post strobe edge N: still idle on the line, already busy
        n_checks++; if (tx !== 1'b1)   $display("FAIL t1_tx_edgeN: got %b want 1", tx);     else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL t1_busy_edgeN: got %b want 1", busy); else n_pass++;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            k = c - 1;
            if (c == 41)           e = 1'b1;
            else if (k < CPB)      e = 1'b0;
            else if (k < 9 * CPB)  e = b[(k - CPB) / CPB];
            else                   e = 1'b1;
            n_checks++;
            if (tx !== e) $display("FAIL t1_wave c=%0d: got %b want %b", c, tx, e); else n_pass++;
            if (c == 40) begin
                n_checks++; if (busy !== 1'b1) $display("FAIL t1_busy_c40: got %b want 1", busy); else n_pass++;
            end
            if (c == 41) begin
                n_checks++; if (busy !== 1'b0) $display("FAIL t1_busy_c41: got %b want 0", busy); else n_pass++;
            end
        end
        settle_idle(50, to);
        n_checks++; if (to) $display("FAIL t1_timeout: busy still %b want 0", busy); else n_pass++;
        n_checks++;
        if (rx_q.size() != exp_q.size()) $display("FAIL t1_frames: got %0d want %0d", rx_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] ex, rv;
            ex = exp_q.pop_front();
            rv = rx_q.pop_front();
            n_checks++; if (rv !== ex) $display("FAIL t1_byte: got %h want %h", rv, ex); else n_pass++;
        end
        exp_q.delete(); rx_q.delete(); rx_start_q.delete();
    endtask

    task automatic test_overflow();
        bit to;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 17) begin
                n_checks++; if (full !== 1'b1) $display("FAIL t2_full_e16: got %b want 1", full); else n_pass++;
                n_checks++; if (ovf !== 1'b0)  $display("FAIL t2_ovf_e16: got %b want 0", ovf);   else n_pass++;
            end
            if (i == 18) begin
                n_checks++; if (ovf !== 1'b1)  $display("FAIL t2_ovf_e17: got %b want 1", ovf);   else n_pass++;
            end
            rdy = 1'b1;
            din = 8'(i);
            if (i <= 16) exp_q.push_back(8'(i));
        end
        @(negedge clk);
        rdy = 1'b0;
        settle_idle(17 * (10 * CPB + 1) + 50, to);
        n_checks++; if (to) $display("FAIL t2_timeout: busy still %b want 0", busy); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL t2_ovf_sticky: got %b want 1", ovf); else n_pass++;
        n_checks++;
        if (rx_q.size() != exp_q.size()) $display("FAIL t2_frames: got %0d want %0d", rx_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] ex, rv;
            ex = exp_q.pop_front();
            rv = rx_q.pop_front();
            n_checks++; if (rv !== ex) $display("FAIL t2_byte: got %h want %h", rv, ex); else n_pass++;
        end
        do_reset();
        n_checks++; if (ovf !== 1'b0) $display("FAIL t2_ovf_cleared: got %b want 0", ovf); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        // 18 strobes: first goes on the line, 16 fill the FIFO, last overflows
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rdy = 1'b1;
            din = 8'hA0 + 8'(i);
        end
        @(negedge clk);
        rdy = 1'b0;
        n_checks++; if (ovf !== 1'b1)  $display("FAIL t3_pre_ovf: got %b want 1", ovf);   else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL t3_pre_full: got %b want 1", full); else n_pass++;
        @(negedge clk);
        // line is in DATA bit 3 of 0xA0 (bit value 0)
        n_checks++; if (tx !== 1'b0) $display("FAIL t3_pre_tx: got %b want 0", tx); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (tx !== 1'b1)   $display("FAIL t3_tx: got %b want 1", tx);     else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL t3_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL t3_full: got %b want 0", full); else n_pass++;
        n_checks++; if (ovf !== 1'b0)  $display("FAIL t3_ovf: got %b want 0", ovf);   else n_pass++;
        exp_q.delete(); rx_q.delete(); rx_start_q.delete();
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h55);
        strobe(8'h55);
        settle_idle(100, to);
        n_checks++; if (to) $display("FAIL t3_timeout: busy still %b want 0", busy); else n_pass++;
        n_checks++;
        if (rx_q.size() != exp_q.size()) $display("FAIL t3_frames: got %0d want %0d", rx_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] ex, rv;
            ex = exp_q.pop_front();
            rv = rx_q.pop_front();
            n_checks++; if (rv !== ex) $display("FAIL t3_byte: got %h want %h", rv, ex); else n_pass++;
        end
        exp_q.delete(); rx_q.delete(); rx_start_q.delete();
    endtask

    task automatic test_crlf();
        int n, want_fall;
        exp_q.push_back(8'h0D);
`ifdef ENIGMA_TX_CRLF_EN
        exp_q.push_back(8'h0A);
        want_fall = 2 * (10 * CPB + 1);
`else
        want_fall = 10 * CPB + 1;
`endif
        strobe(8'h0D);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (n != want_fall) $display("FAIL t4_busy_fall: got %0d clks want %0d", n, want_fall); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_q.size() != exp_q.size()) $display("FAIL t4_frames: got %0d want %0d", rx_q.size(), exp_q.size());
        else n_pass++;
`ifdef ENIGMA_TX_CRLF_EN
        if (rx_start_q.size() == 2) begin
            n_checks++;
            if (rx_start_q[1] - rx_start_q[0] != 10 * CPB + 1)
                $display("FAIL t4_gap: got %0d want %0d", rx_start_q[1] - rx_start_q[0], 10 * CPB + 1);
            else n_pass++;
        end
`endif
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] ex, rv;
            ex = exp_q.pop_front();
            rv = rx_q.pop_front();
            n_checks++; if (rv !== ex) $display("FAIL t4_byte: got %h want %h", rv, ex); else n_pass++;
        end
        exp_q.delete(); rx_q.delete(); rx_start_q.delete();
    endtask

    task automatic test_back_to_back();
        bit to;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        strobe(8'h3C);
        repeat (9 * CPB + 1) @(negedge clk);
        // first frame is in STOP: strobe the second byte now
        n_checks++; if (tx !== 1'b1) $display("FAIL t5_in_stop: got %b want 1", tx); else n_pass++;
        rdy = 1'b1;
        din = 8'hC3;
        @(negedge clk);
        rdy = 1'b0;
        settle_idle(200, to);
        n_checks++; if (to) $display("FAIL t5_timeout: busy still %b want 0", busy); else n_pass++;
        n_checks++;
        if (rx_start_q.size() != 2) $display("FAIL t5_starts: got %0d want 2", rx_start_q.size());
        else n_pass++;
        if (rx_start_q.size() == 2) begin
            n_checks++;
            if (rx_start_q[1] - rx_start_q[0] != 10 * CPB + 1)
                $display("FAIL t5_gap: got %0d want %0d", rx_start_q[1] - rx_start_q[0], 10 * CPB + 1);
            else n_pass++;
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            logic [7:0] ex, rv;
            ex = exp_q.pop_front();
            rv = rx_q.pop_front();
            n_checks++; if (rv !== ex) $display("FAIL t5_byte: got %h want %h", rv, ex); else n_pass++;
        end
        exp_q.delete(); rx_q.delete(); rx_start_q.delete();
    endtask

    task automatic test_full_slow();
        int n;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 17) begin
                n_checks++; if (s_full !== 1'b1) $display("FAIL t6_full: got %b want 1", s_full); else n_pass++;
                n_checks++; if (s_ovf !== 1'b0)  $display("FAIL t6_ovf_pre: got %b want 0", s_ovf); else n_pass++;
            end
            s_rdy = 1'b1;
            s_din = 8'(i) ^ 8'h5A;
        end
        @(negedge clk);
        s_rdy = 1'b0;
        n_checks++; if (s_ovf !== 1'b1)  $display("FAIL t6_ovf: got %b want 1", s_ovf);         else n_pass++;
        n_checks++; if (s_full !== 1'b1) $display("FAIL t6_full_after: got %b want 1", s_full); else n_pass++;
        n = 0;
        while (s_full === 1'b1 && n < 12 * CPB_SLOW) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (s_full !== 1'b0) $display("FAIL t6_full_after_pop: got %b want 0", s_full); else n_pass++;
        @(negedge clk);
        s_rdy = 1'b1;
        s_din = 8'h99;
        @(negedge clk);
        s_rdy = 1'b0;
        n_checks++; if (s_full !== 1'b1) $display("FAIL t6_refill: got %b want 1", s_full); else n_pass++;
        n_checks++; if (s_ovf !== 1'b1)  $display("FAIL t6_ovf_sticky: got %b want 1", s_ovf); else n_pass++;
        @(negedge clk);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        n_checks++; if (s_busy !== 1'b0) $display("FAIL t6_reset_busy: got %b want 0", s_busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_reset_mid_frame();
        test_crlf();
        test_back_to_back();
        test_full_slow();
        n_checks++; if (mon_err != 0) $display("FAIL line_framing: got %0d errors want 0", mon_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_enigma_uart_tx
`default_nettype wire
